// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: carries BTB lookups through IF/ID and ID/EX, resolves branches in EX, issues filtered BTB writes.
// Define BTB_STATS_EN to add saturating branch_cnt / mispredict_cnt outputs.
module btb_update_ctrl #(
   parameter int CNT_ADDR_LEN = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   input  logic [31:0] if_pc,
   input  logic        if_predicted,
   input  logic [31:0] if_predicted_pc,
   input  logic        id_stall,
   input  logic        ex_stall,
   input  logic        id_flush,
   input  logic        ex_is_branch,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic        wr_req,
   output logic [31:0] wr_PC,
   output logic [31:0] wr_predicted_PC
`ifdef BTB_STATS_EN
   ,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispredict_cnt
`endif
);
   localparam int N = 1 << CNT_ADDR_LEN;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        pred;
      logic [31:0] pred_pc;
   } slot_t;
   slot_t ifid, idex;
   logic [1:0] cnt [N];
   logic [CNT_ADDR_LEN-1:0] idx;
   logic [31:0] pc4, actual_next, pred_next;
   logic [1:0] cnt_old, cnt_new;
   logic resolve, wr_take, wr_nt, do_wr;
   always_comb begin
      idx = idex.pc[CNT_ADDR_LEN+1:2];
      pc4 = idex.pc + 32'd4;
      resolve = idex.valid & ex_is_branch & ~ex_stall;
      actual_next = ex_taken ? ex_target : pc4;
      pred_next = idex.pred ? idex.pred_pc : pc4;
      mispredict = resolve & (actual_next != pred_next);
      redirect_pc = resolve ? actual_next : 32'd0;
      cnt_old = cnt[idx];
      cnt_new = ex_taken ? ((cnt_old == 2'd3) ? 2'd3 : cnt_old + 2'd1)
                         : ((cnt_old == 2'd0) ? 2'd0 : cnt_old - 2'd1);
      wr_take = ex_taken & (~idex.pred | (idex.pred_pc != ex_target));
      // no invalidate on the BTB: rewriting with fall-through neutralises the entry
      wr_nt = ~ex_taken & idex.pred & (idex.pred_pc != pc4) & (cnt_new <= 2'd1);
      do_wr = resolve & (wr_take | wr_nt);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ifid <= '0;
         idex <= '0;
         wr_req <= 1'b0;
         wr_PC <= 32'd0;
         wr_predicted_PC <= 32'd0;
         for (int i = 0; i < N; i++) cnt[i] <= 2'b01;
      end else begin
         if (mispredict || id_flush) ifid.valid <= 1'b0;
         else if (!(ex_stall || id_stall)) ifid <= {if_valid, if_pc, if_predicted, if_predicted_pc};
         if (mispredict || (!ex_stall && id_stall)) idex.valid <= 1'b0;
         else if (!ex_stall) idex <= ifid;
         wr_req <= do_wr;
         if (do_wr) begin
            wr_PC <= idex.pc;
            wr_predicted_PC <= ex_taken ? ex_target : pc4;
         end
         if (resolve) cnt[idx] <= cnt_new;
      end
`ifdef BTB_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         branch_cnt <= 32'd0;
         mispredict_cnt <= 32'd0;
      end else begin
         if (resolve && branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
         if (mispredict && mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + 32'd1;
      end
`endif
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed vectors with hand-computed expectations for btb_update_ctrl.
module tb_btb_update_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid, if_predicted, id_stall, ex_stall, id_flush, ex_is_branch, ex_taken;
   logic [31:0] if_pc, if_predicted_pc, ex_target;
   logic        mispredict, wr_req;
   logic [31:0] redirect_pc, wr_PC, wr_predicted_PC;
`ifdef BTB_STATS_EN
   logic [31:0] branch_cnt, mispredict_cnt;
`endif
   int n_chk = 0;
   int n_fail = 0;

   btb_update_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_pc(if_pc), .if_predicted(if_predicted), .if_predicted_pc(if_predicted_pc),
      .id_stall(id_stall), .ex_stall(ex_stall), .id_flush(id_flush),
      .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .wr_req(wr_req), .wr_PC(wr_PC), .wr_predicted_PC(wr_predicted_PC)
`ifdef BTB_STATS_EN
      , .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // called just after a negedge; returns with the instruction sitting in ID/EX
   task automatic load(input logic [31:0] pc, input logic pred, input logic [31:0] ppc);
      ex_is_branch = 1'b0;
      if_valid = 1'b1;
      if_pc = pc;
      if_predicted = pred;
      if_predicted_pc = ppc;
      @(negedge clk);
      if_valid = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic resolve(input logic tk, input logic [31:0] tgt, input logic exp_mp,
                          input logic [31:0] exp_rd, input logic exp_wr,
                          input logic [31:0] exp_pc, input logic [31:0] exp_ppc, input string tag);
      ex_is_branch = 1'b1;
      ex_taken = tk;
      ex_target = tgt;
      #1;
      chk({tag, "_mp"}, 32'(mispredict), 32'(exp_mp));
      chk({tag, "_redir"}, redirect_pc, exp_rd);
      @(negedge clk);
      ex_is_branch = 1'b0;
      #1;
      chk({tag, "_wr_req"}, 32'(wr_req), 32'(exp_wr));
      chk({tag, "_wr_pc"}, wr_PC, exp_pc);
      chk({tag, "_wr_ppc"}, wr_predicted_PC, exp_ppc);
   endtask

   initial begin
      rst_n = 1'b0;
      {if_valid, if_predicted, id_stall, ex_stall, id_flush, ex_is_branch, ex_taken} = '0;
      if_pc = '0;
      if_predicted_pc = '0;
      ex_target = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_wr_req", 32'(wr_req), 32'd0);
      chk("rst_wr_pc", wr_PC, 32'd0);
      chk("rst_wr_ppc", wr_predicted_PC, 32'd0);
      chk("rst_mp", 32'(mispredict), 32'd0);
`ifdef BTB_STATS_EN
      chk("rst_branch_cnt", branch_cnt, 32'd0);
`endif
      // cold miss, taken, with a younger instruction in IF that must die
      load(32'h100, 1'b0, 32'h0);
      if_valid = 1'b1;
      if_pc = 32'h200;
      if_predicted = 1'b0;
      ex_is_branch = 1'b1;
      ex_taken = 1'b1;
      ex_target = 32'h80;
      #1;
      chk("cold_mp", 32'(mispredict), 32'd1);
      chk("cold_redir", redirect_pc, 32'h80);
      @(negedge clk);
      if_valid = 1'b0;
      #1;
      chk("cold_wr_req", 32'(wr_req), 32'd1);
      chk("cold_wr_pc", wr_PC, 32'h100);
      chk("cold_wr_ppc", wr_predicted_PC, 32'h80);
      chk("cold_ex_killed", 32'(mispredict), 32'd0);
      @(negedge clk);
      #1;
      chk("cold_wr_pulse", 32'(wr_req), 32'd0);
      chk("cold_young_killed", 32'(mispredict), 32'd0);
      ex_is_branch = 1'b0;
      // counter for 0x100: 2 after cold miss
      load(32'h100, 1'b1, 32'h80);
      resolve(1'b1, 32'h80, 1'b0, 32'h80, 1'b0, 32'h100, 32'h80, "hit");
      load(32'h100, 1'b1, 32'h80);
      resolve(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h100, 32'h80, "hyst1");
      load(32'h100, 1'b1, 32'h80);
      resolve(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 32'h100, 32'h104, "hyst2");
      load(32'hFFFF_FFFC, 1'b1, 32'h80);
      resolve(1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0, "wrap");
      load(32'h100, 1'b1, 32'h80);
      resolve(1'b1, 32'h90, 1'b1, 32'h90, 1'b1, 32'h100, 32'h90, "wrong_tgt");
      load(32'h100, 1'b1, 32'h90);
      resolve(1'b1, 32'h90, 1'b0, 32'h90, 1'b0, 32'h100, 32'h90, "sat_up");
      // EX stall holds the branch and suppresses resolution
      load(32'h204, 1'b1, 32'h300);
      ex_stall = 1'b1;
      ex_is_branch = 1'b1;
      ex_taken = 1'b0;
      if_valid = 1'b1;
      if_pc = 32'h400;
      if_predicted = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_mp", 32'(mispredict), 32'd0);
         chk("stall_redir", redirect_pc, 32'd0);
         chk("stall_wr_req", 32'(wr_req), 32'd0);
         @(negedge clk);
      end
      ex_stall = 1'b0;
      if_valid = 1'b0;
      resolve(1'b0, 32'h0, 1'b1, 32'h208, 1'b1, 32'h204, 32'h208, "unstall");
      // id_flush beats id_stall on IF/ID
      if_valid = 1'b1;
      if_pc = 32'h500;
      if_predicted = 1'b0;
      @(negedge clk);
      if_valid = 1'b0;
      id_flush = 1'b1;
      id_stall = 1'b1;
      @(negedge clk);
      id_flush = 1'b0;
      id_stall = 1'b0;
      @(negedge clk);
      ex_is_branch = 1'b1;
      ex_taken = 1'b1;
      ex_target = 32'h80;
      #1;
      chk("flush_mp", 32'(mispredict), 32'd0);
      ex_is_branch = 1'b0;
      // id_stall inserts a bubble into ID/EX while IF/ID holds
      if_valid = 1'b1;
      @(negedge clk);
      if_valid = 1'b0;
      id_stall = 1'b1;
      @(negedge clk);
      ex_is_branch = 1'b1;
      #1;
      chk("bubble_mp", 32'(mispredict), 32'd0);
      id_stall = 1'b0;
      @(negedge clk);
      #1;
      chk("after_bubble_mp", 32'(mispredict), 32'd1);
      chk("after_bubble_redir", redirect_pc, 32'h80);
      @(negedge clk);
      ex_is_branch = 1'b0;
      #1;
      chk("after_bubble_wr_pc", wr_PC, 32'h500);
      // reset while a write is in flight
      load(32'h600, 1'b0, 32'h0);
      ex_is_branch = 1'b1;
      ex_taken = 1'b1;
      ex_target = 32'h700;
      #1;
      chk("pre_rst_mp", 32'(mispredict), 32'd1);
      @(negedge clk);
      ex_is_branch = 1'b0;
      #1;
      chk("pre_rst_wr_req", 32'(wr_req), 32'd1);
      chk("pre_rst_wr_pc", wr_PC, 32'h600);
      rst_n = 1'b0;
      #1;
      chk("async_rst_wr_req", 32'(wr_req), 32'd0);
      chk("async_rst_wr_pc", wr_PC, 32'd0);
      chk("async_rst_wr_ppc", wr_predicted_PC, 32'd0);
`ifdef BTB_STATS_EN
      chk("async_rst_branch_cnt", branch_cnt, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      // counter for 0x100 was 3 before reset; back at 1 a single not-taken writes
      load(32'h100, 1'b1, 32'h80);
      resolve(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 32'h100, 32'h104, "post_rst");
`ifdef BTB_STATS_EN
      chk("stats_branch_cnt", branch_cnt, 32'd1);
      chk("stats_mispredict_cnt", mispredict_cnt, 32'd1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Branch resolution and update engine that drives the Branch Target Buffer's write port: wr_req, wr_PC and wr_predicted_PC.
- Carries each fetched PC's BTB lookup result (hit bit and predicted PC) through the IF/ID and ID/EX pipeline slots.
- In EX, compares the prediction with the resolved outcome, raises mispredict plus a redirect PC, and issues BTB writes filtered by a 2-bit hysteresis table.

Parameters:
CNT_ADDR_LEN, 6, log2 of hysteresis-counter entries; index is PC[CNT_ADDR_LEN+1:2].

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
if_valid  input  1  IF slot holds a real instruction
if_pc  input  32  PC being fetched (same PC applied to BTB rd_PC)
if_predicted  input  1  BTB rd_predicted for if_pc
if_predicted_pc  input  32  BTB rd_predicted_PC for if_pc
id_stall  input  1  hold IF/ID slot
ex_stall  input  1  hold IF/ID and ID/EX slots; suppress resolution
id_flush  input  1  external kill of IF/ID slot (e.g. jal/jalr redirect)
ex_is_branch  input  1  EX instruction is a conditional branch
ex_taken  input  1  resolved branch direction
ex_target  input  32  resolved taken target
mispredict  output  1  combinational; EX branch predicted wrong
redirect_pc  output  32  combinational; correct next PC when mispredict=1
wr_req  output  1  registered BTB write strobe
wr_PC  output  32  registered branch PC to write
wr_predicted_PC  output  32  registered predicted target to write

Behaviour:
- Reset (rst_n=0, async): all slot valid bits 0, slot fields 0, counters = 2'b01, wr_req=0, wr_PC=0, wr_predicted_PC=0.
- Slot record: {valid, pc, pred, pred_pc}.
- IF/ID update, in priority order:
  - mispredict or id_flush: valid<=0.
  - else ex_stall or id_stall: hold.
  - else load from the if_* inputs.
- ID/EX update, in priority order:
  - mispredict: valid<=0.
  - else ex_stall: hold.
  - else id_stall: valid<=0 (bubble).
  - else load from IF/ID.
- resolve = ex.valid & ex_is_branch & ~ex_stall.
- actual_next = ex_taken ? ex_target : ex.pc+4, computed mod 2^32 (pc 32'hFFFFFFFC wraps to 0).
- pred_next = ex.pred ? ex.pred_pc : ex.pc+4.
- mispredict = resolve & (actual_next != pred_next).
- redirect_pc = actual_next whenever resolve=1; otherwise don't-care, driven 0.
- Counter update on resolve, at the index taken from ex.pc:
  - taken: increment, saturating at 3.
  - not taken: decrement, saturating at 0.
  - cnt_new is the post-update value.
- Write decision on resolve:
  - taken and (~ex.pred or ex.pred_pc != ex_target): write {ex.pc, ex_target}.
  - not taken and ex.pred and ex.pred_pc != ex.pc+4 and cnt_new <= 1: write {ex.pc, ex.pc+4}. The BTB has no invalidate, so this fall-through target neutralises the entry.
  - otherwise: no write.
- Write latency: wr_req high exactly one cycle, on the cycle after resolve. wr_PC and wr_predicted_PC are valid with wr_req and hold their values otherwise.
- Back-to-back resolves: one write per cycle; no queueing needed.
- mispredict ignores id_stall. An EX branch stalled by ex_stall never resolves twice: resolve occurs only on the cycle ex_stall is low.
- rst_n asserted mid-write: wr_req drops immediately (async).

Optional Feature:
BTB_STATS_EN
- Defined: adds outputs branch_cnt[31:0] and mispredict_cnt[31:0].
  - Reset to 0.
  - branch_cnt increments on each resolve; mispredict_cnt increments on each mispredict.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Cold BTB miss, taken: pc=0x100 branch with ex_taken=1, target 0x80; pred=0 → mispredict=1, redirect_pc=0x80. Next cycle wr_req=1, wr_PC=0x100, wr_predicted_PC=0x80; IF/ID and ID/EX valid cleared.
- Correct hit: pred=1, pred_pc=0x80, taken to 0x80 → mispredict=0, no wr_req, counter for 0x100 increments.
- Hysteresis: counter at 3, BTB hit, branch not taken → mispredict=1, redirect_pc=0x104, counter 2, no write. Second not-taken → counter 1, wr_req with wr_predicted_PC=0x104.
- Stall: ex_stall=1 for 3 cycles with branch in EX → mispredict=0 and no counter change during the stall; resolves once on release; ID/EX contents unchanged throughout.
- Flush ordering: id_flush=1 and id_stall=1 same cycle → IF/ID valid=0. Mispredict while if_valid=1 → the younger instruction never reaches EX.
- Reset mid-write: deassert rst_n while wr_req=1 → wr_req=0 immediately, counters 2'b01. With BTB_STATS_EN, branch_cnt=0 after reset.
